// File: rtl/reg_dump_reader.sv
// Register-file dump initiator: walks a wrapping index range and streams each byte out with its address and a last flag.
// Latency: first beat one cycle after start; one beat/cycle with out_ready high. Backpressure: stalls the walk and holds the beat.
module reg_dump_reader #(
    parameter int pw = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [pw-1:0] first_addr,
    input  logic [pw-1:0] last_addr,
    output logic [pw:0]   rd_addr,
    input  logic [7:0]    rd_data,
    output logic [7:0]    out_data,
    output logic [pw-1:0] out_addr,
    output logic          out_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    state_t        state_q;
    logic [pw-1:0] cur_q;
    logic [pw-1:0] cur_d;
    logic [pw-1:0] end_q;
    logic [7:0]    out_data_q;
    logic [pw-1:0] out_addr_q;
    logic          out_last_q;
    logic          out_valid_q;
    logic          busy_q;
    logic          done_q;
    logic          out_free;

    // Index wraps naturally modulo 2**pw, which gives wrap-around ranges for free.
    assign cur_d    = cur_q + 1'b1;
    assign out_free = !out_valid_q || out_ready;
    assign rd_addr  = (state_q == RUN) ? {1'b0, cur_q} : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            end_q       <= '0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        cur_q   <= first_addr;
                        end_q   <= last_addr;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (out_free) begin
                        out_data_q  <= rd_data;
                        out_addr_q  <= cur_q;
                        out_last_q  <= (cur_q == end_q);
                        out_valid_q <= 1'b1;
                        if (cur_q == end_q) begin
                            state_q <= DRAIN;
                        end else begin
                            cur_q <= cur_d;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= FIN;
                    end
                end
                FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_addr  = out_addr_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: register-file model, scoreboard of expected beats, per-scenario tasks.
module tb_reg_dump_reader;

    localparam int PW = 3;

    typedef struct packed {
        logic [PW-1:0] addr;
        logic [7:0]    data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [PW-1:0] first_addr = '0;
    logic [PW-1:0] last_addr = '0;
    logic [PW:0]   rd_addr;
    logic [7:0]    rd_data;
    logic [7:0]    out_data;
    logic [PW-1:0] out_addr;
    logic          out_last;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          done;

    logic [7:0]    regs [8];
    logic          wr_en = 1'b0;
    logic [PW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_n = 0;
    int done_cyc = 0;
    int acc_n = 0;
    int first_acc = 0;
    int last_acc = 0;
    logic busy_at_done = 1'b0;
    logic held_v = 1'b0;
    logic [15:0] held = '0;
    beat_t exp_q [$];

    reg_dump_reader #(.pw(PW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .first_addr(first_addr), .last_addr(last_addr),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) regs[wr_addr] <= wr_data;
    end

    assign rd_data = regs[rd_addr[PW-1:0]];

    // Consumer side: checks every accepted beat against the scoreboard and that stalled beats hold still.
    always @(negedge clk) begin
        if (reset) begin
            held_v = 1'b0;
        end else begin
            if (held_v && out_valid) begin
                total++;
                if ({out_data, out_addr, out_last, rd_addr} !== held) begin
                    bad++;
                    $display("FAIL stall_hold got=%h exp=%h", {out_data, out_addr, out_last, rd_addr}, held);
                end
            end
            held_v = out_valid && !out_ready;
            held = {out_data, out_addr, out_last, rd_addr};
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat got addr=%0d data=%h exp=none", out_addr, out_data);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if ({out_addr, out_data, out_last} !== e) begin
                        bad++;
                        $display("FAIL beat got addr=%0d data=%h last=%b exp addr=%0d data=%h last=%b",
                                 out_addr, out_data, out_last, e.addr, e.data, e.last);
                    end
                end
                acc_n++;
                if (acc_n == 1) first_acc = cyc;
                last_acc = cyc;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [PW-1:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic push_range(input logic [PW-1:0] f, input logic [PW-1:0] l);
        logic [PW-1:0] a;
        a = f;
        forever begin
            exp_q.push_back({a, regs[a], (a == l)});
            if (a == l) break;
            a = a + 1'b1;
        end
    endtask

    task automatic pulse_start(input logic [PW-1:0] f, input logic [PW-1:0] l);
        first_addr = f; last_addr = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives out_ready (mode 0: always high, mode 1: 1,0,0 repeating) until done is seen or the budget expires.
    task automatic run_ready(input int mode, input int budget);
        int base;
        int n;
        base = done_n;
        n = 0;
        while (done_n == base && n < budget) begin
            out_ready = (mode == 0) ? 1'b1 : ((n % 3) == 0);
            tick();
            n++;
        end
        out_ready = 1'b1;
        if (done_n == base) begin
            total++; bad++;
            $display("FAIL done_timeout got=none exp=done within %0d cycles", budget);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
        total++; if ({out_data, out_addr, out_last, rd_addr} !== 16'h0) begin
            bad++; $display("FAIL rst_outs got=%h exp=0", {out_data, out_addr, out_last, rd_addr});
        end
        reset = 1'b0;
        for (int i = 0; i < 8; i++) wr_reg(i[PW-1:0], 8'h10 + 8'(i));
    endtask

    task automatic test_basic();
        int base;
        base = done_n;
        acc_n = 0;
        out_ready = 1'b1;
        push_range(3'd2, 3'd5);
        pulse_start(3'd2, 3'd5);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_first_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
        total++; if (rd_addr !== 4'd2) begin bad++; $display("FAIL basic_rd_addr got=%0d exp=2", rd_addr); end
        tick();
        total++; if (out_valid !== 1'b1 || out_addr !== 3'd2) begin
            bad++; $display("FAIL basic_first_beat got=%b/%0d exp=1/2", out_valid, out_addr);
        end
        run_ready(0, 40);
        total++; if (acc_n !== 4) begin bad++; $display("FAIL basic_count got=%0d exp=4", acc_n); end
        total++; if (last_acc - first_acc !== 3) begin bad++; $display("FAIL basic_spacing got=%0d exp=3", last_acc - first_acc); end
        total++; if (done_cyc !== last_acc + 1) begin bad++; $display("FAIL basic_done_time got=%0d exp=%0d", done_cyc, last_acc + 1); end
        total++; if (busy_at_done !== 1'b1) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=1", busy_at_done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_after got=%b exp=0", busy); end
        total++; if (done_n !== base + 1) begin bad++; $display("FAIL basic_done_n got=%0d exp=%0d", done_n, base + 1); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL basic_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_stall();
        int base;
        base = done_n;
        acc_n = 0;
        out_ready = 1'b0;
        push_range(3'd2, 3'd5);
        pulse_start(3'd2, 3'd5);
        run_ready(1, 80);
        total++; if (acc_n !== 4) begin bad++; $display("FAIL stall_count got=%0d exp=4", acc_n); end
        total++; if (done_n !== base + 1) begin bad++; $display("FAIL stall_done_n got=%0d exp=%0d", done_n, base + 1); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL stall_left got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        logic [PW-1:0] fs [3];
        logic [PW-1:0] ls [3];
        int            ns [3];
        fs = '{3'd6, 3'd3, 3'd4};
        ls = '{3'd1, 3'd3, 3'd3};
        ns = '{4, 1, 8};
        for (int k = 0; k < 3; k++) begin
            int base;
            base = done_n;
            acc_n = 0;
            out_ready = 1'b1;
            push_range(fs[k], ls[k]);
            pulse_start(fs[k], ls[k]);
            run_ready(0, 60);
            total++; if (acc_n !== ns[k]) begin bad++; $display("FAIL wrap_count%0d got=%0d exp=%0d", k, acc_n, ns[k]); end
            total++; if (done_n !== base + 1) begin bad++; $display("FAIL wrap_done%0d got=%0d exp=%0d", k, done_n, base + 1); end
            total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL wrap_left%0d got=%0d exp=0", k, exp_q.size()); end
        end
    endtask

    task automatic test_capture();
        out_ready = 1'b1;
        // Write landing one edge before r[4] is captured: new value seen.
        exp_q.push_back({3'd2, 8'h12, 1'b0});
        exp_q.push_back({3'd3, 8'h13, 1'b0});
        exp_q.push_back({3'd4, 8'hAA, 1'b0});
        exp_q.push_back({3'd5, 8'h15, 1'b1});
        pulse_start(3'd2, 3'd5);
        tick();
        wr_reg(3'd4, 8'hAA);
        run_ready(0, 40);
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL capture_new_left got=%0d exp=0", exp_q.size()); end
        wr_reg(3'd4, 8'h14);
        // Write landing on the capture edge itself: old value seen.
        exp_q.push_back({3'd2, 8'h12, 1'b0});
        exp_q.push_back({3'd3, 8'h13, 1'b0});
        exp_q.push_back({3'd4, 8'h14, 1'b0});
        exp_q.push_back({3'd5, 8'h15, 1'b1});
        pulse_start(3'd2, 3'd5);
        tick();
        tick();
        wr_reg(3'd4, 8'hBB);
        run_ready(0, 40);
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL capture_old_left got=%0d exp=0", exp_q.size()); end
        wr_reg(3'd4, 8'h14);
    endtask

    task automatic test_busy_start();
        int base;
        base = done_n;
        out_ready = 1'b1;
        push_range(3'd2, 3'd5);
        pulse_start(3'd2, 3'd5);
        pulse_start(3'd0, 3'd7);
        run_ready(0, 40);
        repeat (8) tick();
        total++; if (done_n !== base + 1) begin bad++; $display("FAIL busy_start_done got=%0d exp=%0d", done_n, base + 1); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL busy_start_left got=%0d exp=0", exp_q.size()); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_start_busy got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        int base;
        base = done_n;
        out_ready = 1'b0;
        push_range(3'd0, 3'd7);
        pulse_start(3'd0, 3'd7);
        repeat (2) tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_pending got=%b exp=1", out_valid); end
        reset = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        reset = 1'b0;
        exp_q.delete();
        repeat (4) tick();
        total++; if (done_n !== base) begin bad++; $display("FAIL rmid_no_done got=%0d exp=%0d", done_n, base); end
        acc_n = 0;
        out_ready = 1'b1;
        push_range(3'd5, 3'd6);
        pulse_start(3'd5, 3'd6);
        run_ready(0, 40);
        total++; if (acc_n !== 2) begin bad++; $display("FAIL rmid_restart_count got=%0d exp=2", acc_n); end
        total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rmid_restart_left got=%0d exp=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_wrap();
        test_capture();
        test_busy_start();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=still running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side initiator for the processor register file.
- On a start pulse, walks a contiguous (optionally wrapping) range of register addresses and drives the file's combinational read address.
- Captures each returned byte and streams it out over a valid/ready interface, tagged with its address and a last flag.
- Used for debug readback and for register-file dumps to the test harness.

Parameters:
- pw, 3, address pointer parameter; register count is 2**pw (8), read address width is pw+1 (4).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a dump; ignored while busy=1
- first_addr  input  pw  first register index of the range
- last_addr  input  pw  last register index of the range, inclusive
- rd_addr  output  pw+1  read address to the register file; MSB always 0
- rd_data  input  8  combinational read data returned for rd_addr in the same cycle
- out_data  output  8  captured register value
- out_addr  output  pw  index the out_data was read from
- out_last  output  1  high with the final beat of a dump
- out_valid  output  1  beat available
- out_ready  input  1  consumer accepts the beat when out_valid&&out_ready at a clock edge
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Clock/reset fixed: one clock, clk; synchronous active-high reset.
- Reset values: all outputs 0, FSM=IDLE, internal cur=0.
- Reset mid-dump aborts immediately: no done pulse, pending beat discarded.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - rd_addr=0.
  - start=1 latches cur<=first_addr and end<=last_addr; go to RUN.
  - first_addr/last_addr are sampled only at that edge.
- RUN:
  - rd_addr={1'b0,cur}.
  - Output register is free when out_valid==0 or out_ready==1.
  - If free: out_data<=rd_data, out_addr<=cur, out_last<=(cur==end), out_valid<=1.
  - After a load, if cur==end go to DRAIN; else cur<=cur+1 modulo 2**pw.
  - If not free: hold cur and all outputs.
- DRAIN:
  - Wait for out_valid&&out_ready.
  - On that edge: out_valid<=0, out_last<=0; go to FIN.
- FIN: done=1 for exactly one cycle; return to IDLE.
- busy=1 in RUN, DRAIN and FIN; 0 in IDLE.
- Throughput: one beat per cycle while out_ready is held high.
- First beat: out_valid rises one cycle after the start edge.
- Beat count = ((last_addr-first_addr) mod 2**pw)+1.
  - first==last: exactly 1 beat.
  - first>last: wraps, e.g. 6,7,0,1.
  - Full dump of all 2**pw registers: first=k, last=k-1 mod 2**pw.
- Stability: while out_valid=1 and out_ready=0, out_data, out_addr and out_last hold constant.
- Value capture: each value is the register content at the cycle it is captured, not at start.
  - A same-cycle register-file write to the address being read returns the old value (the write lands at the edge).
- start during busy has no effect and is not queued.
- start in the FIN cycle is ignored; earliest restart is the cycle after done.

Test Plan:
- Reset, then load regs r[i]=8'h10+i. Pulse start with first=2, last=5, out_ready=1 → beats (2,12),(3,13),(4,14),(5,15) on consecutive cycles. out_last only on addr 5. done one cycle after the last accept. busy drops with done.
- Same range with out_ready toggling 1,0,0,1,... → no beat lost or duplicated; data/addr held while stalled; rd_addr holds during stall.
- first=6, last=1 → addresses 6,7,0,1 in order. first=3, last=3 → single beat with out_last=1. first=4, last=3 → 8 beats, 4..7,0..3.
- Mid-dump: write r[4]=8'hAA one cycle before addr 4 is captured → beat shows AA. Write r[4] in the capture cycle → beat shows old 14.
- start pulsed again while busy (first=0) → ignored; the original sequence completes unchanged and yields exactly one done.
- reset asserted while out_valid=1 and out_ready=0 → next cycle: out_valid=0, busy=0, no done. A fresh start afterwards dumps correctly from first_addr.
